// File: rtl/playback_sequencer.sv
// Playback sequencer: walks the note memory, times each note in AUTOPLAY
// and waits for matching keys in LEARNING, counting hits and misses.
module playback_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_250_000,
    parameter int MEM_TIMEOUT = 1024,
    parameter int MAX_NOTES   = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic [4:0]            key_in,
    input  logic                  key_valid,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_ready,
    output logic                  mem_read_en,
    output logic                  mem_read_rst,
    output logic [4:0]            note_out,
    output logic                  note_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [7:0]            hit_count,
    output logic [7:0]            miss_count
);

    localparam int FW = $clog2(MAX_NOTES + 1);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [31:0] GAP_LOAD = 32'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, REWIND, FETCH, WAIT, PLAY, PROMPT, GAP, DONE
    } state_t;

    state_t        state;
    logic [1:0]    run_mode;
    logic [31:0]   timer;
    logic [WW-1:0] wait_cnt;
    logic [FW-1:0] fetch_cnt;
    logic          nv_q;
    logic          abort;
    logic [3:0]    units;
    logic [31:0]   play_load;

    assign busy  = (state != IDLE) && (state != DONE);
    assign done  = (state == DONE);
    assign abort = busy && (stop || (mode != run_mode));

    // pause and abort silence the tone in the same cycle they arrive
    assign note_valid = nv_q && !pause && !abort;

    assign units     = (mem_data[2:0] == 3'd0) ? 4'd8 : {1'b0, mem_data[2:0]};
    assign play_load = 32'(units) * 32'(BEAT_CYCLES) - 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            run_mode     <= 2'b00;
            timer        <= '0;
            wait_cnt     <= '0;
            fetch_cnt    <= '0;
            nv_q         <= 1'b0;
            note_out     <= 5'd0;
            mem_read_en  <= 1'b0;
            mem_read_rst <= 1'b0;
            timeout_err  <= 1'b0;
            hit_count    <= 8'd0;
            miss_count   <= 8'd0;
        end else begin
            mem_read_en  <= 1'b0;
            mem_read_rst <= 1'b0;
            if (abort) begin
                state        <= IDLE;
                mem_read_rst <= 1'b1;
                nv_q         <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, DONE: begin
                        if (stop) begin
                            state <= IDLE;
                        end else if (start && !mode[1]) begin
                            state        <= REWIND;
                            run_mode     <= mode;
                            mem_read_rst <= 1'b1;
                            hit_count    <= 8'd0;
                            miss_count   <= 8'd0;
                            timeout_err  <= 1'b0;
                            fetch_cnt    <= '0;
                        end
                    end
                    REWIND: state <= FETCH;
                    FETCH: begin
                        if (fetch_cnt == FW'(MAX_NOTES)) begin
                            state <= DONE;
                        end else begin
                            mem_read_en <= 1'b1;
                            fetch_cnt   <= fetch_cnt + 1'b1;
                            wait_cnt    <= '0;
                            state       <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (mem_ready) begin
                            if (mem_data == '0) begin
                                state <= DONE;
                            end else begin
                                note_out <= mem_data[7:3];
                                nv_q     <= (mem_data[7:3] != 5'd0);
                                timer    <= play_load;
                                state    <= run_mode[0] ? PROMPT : PLAY;
                            end
                        end else if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
                            timeout_err <= 1'b1;
                            state       <= DONE;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    PLAY: begin
                        if (!pause) begin
                            if (timer == 32'd0) begin
                                nv_q  <= 1'b0;
                                timer <= GAP_LOAD;
                                state <= GAP;
                            end else begin
                                timer <= timer - 32'd1;
                            end
                        end
                    end
                    PROMPT: begin
                        if (note_out == 5'd0) begin
                            nv_q  <= 1'b0;
                            timer <= GAP_LOAD;
                            state <= GAP;
                        end else if (!pause && key_valid) begin
                            if (key_in == note_out) begin
                                if (hit_count != 8'hFF)
                                    hit_count <= hit_count + 8'd1;
                                nv_q  <= 1'b0;
                                timer <= GAP_LOAD;
                                state <= GAP;
                            end else if (miss_count != 8'hFF) begin
                                miss_count <= miss_count + 8'd1;
                            end
                        end
                    end
                    GAP: begin
                        if (!pause) begin
                            if (timer == 32'd0)
                                state <= FETCH;
                            else
                                timer <= timer - 32'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
